core_sequencer: RTL and testbench

Multi-cycle sequencer for the simplified RISC core. It steps each instruction through fetch, decode, execute, memory and write-back states. It shares the single memory port between instruction fetch and data load, and issues the per-state datapath controls: register write, ALU operand select and write-back mux select. It sits between the instruction register / register file / ALU datapath and the unified memory port, and replaces direct decode-to-datapath control with a sequenced equivalent.

---
 rtl/core_sequencer.sv | 176 +++++++++++++++++
 tb/tb_core_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle instruction sequencer for the simplified RISC core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It shares the
// unified memory port between instruction fetch and data load, and issues the
// per-state datapath controls.
//
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   run            level enable; a new instruction is fetched only while high
//   ir_opcode      opcode field of the instruction register (used in DECODE)
//   mem_ack        memory completion, honoured only while mem_req is high
//   mem_req        memory request (FETCH / MEM)
//   mem_sel        0 = instruction fetch, 1 = data load
//   ir_load        capture read data into the IR (FETCH & mem_ack)
//   alu_src        ALU operand B: 1 = immediate, 0 = register
//   mem_to_reg     write-back mux: 1 = memory data, 0 = ALU result
//   reg_write      register file write enable
//   pc_inc         advance PC by 4
//   busy           state is neither IDLE nor HALT
//   illegal_instr  sticky: unsupported opcode decoded
//   bus_err        sticky: memory timeout, FSM parked in HALT
//   instr_count    retired-instruction counter, wraps modulo 2^CNT_W
module core_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       ir_opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             ir_load,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_inc,
  output logic             busy,
  output logic             illegal_instr,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE, C_RTYPE, C_LOAD
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             ill_q, ill_d;
  logic             berr_q, berr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;
  logic             timeout;

  // State, class, timeout counter, sticky flags and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      tcnt_q  <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      tcnt_q  <= tcnt_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-state controls
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    tcnt_d     = tcnt_q;
    ill_d      = ill_q;
    berr_d     = berr_q;
    cnt_d      = cnt_q;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    ir_load    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_inc     = 1'b0;
    busy       = 1'b0;

    // A no-ack cycle in a memory state; the ack in the final allowed cycle wins
    mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;
    timeout  = mem_wait && (TIMEOUT_CYCLES != 0) && (tcnt_q == TLAST);

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        if (ir_opcode == OP_RTYPE) begin
          cls_d   = C_RTYPE;
          state_d = S_EXEC;
        end else if (ir_opcode == OP_LOAD) begin
          cls_d   = C_LOAD;
          state_d = S_EXEC;
        end else begin
          // Skip the bad instruction without retiring it
          cls_d   = C_NONE;
          ill_d   = 1'b1;
          pc_inc  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        alu_src = (cls_q == C_LOAD);
        state_d = (cls_q == C_LOAD) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        alu_src = 1'b1;
        busy    = 1'b1;
        if (mem_ack)      state_d = S_WB;
        else if (timeout) state_d = S_HALT;
      end
      S_WB: begin
        busy       = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LOAD);
        pc_inc     = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        state_d    = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_HALT) berr_d = 1'b1;

    // Any state change (including entry to FETCH/MEM) restarts the wait count
    if (state_d != state_q)                      tcnt_d = '0;
    else if (mem_wait && (TIMEOUT_CYCLES != 0))  tcnt_d = tcnt_q + TW'(1);
  end

  assign illegal_instr = ill_q;
  assign bus_err       = berr_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-cycle {inputs, expected outputs}
// records are built from instruction-level scenarios, then applied in a loop.
module tb_core_sequencer;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_L = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [6:0] ir_opcode;
  logic       mem_ack;
  logic       mem_req, mem_sel, ir_load, alu_src, mem_to_reg, reg_write, pc_inc;
  logic       busy, illegal_instr, bus_err;
  logic [1:0] instr_count;
  logic [11:0] outs;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir_opcode(ir_opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_sel(mem_sel), .ir_load(ir_load), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_inc(pc_inc), .busy(busy),
    .illegal_instr(illegal_instr), .bus_err(bus_err), .instr_count(instr_count)
  );

  assign outs = {mem_req, mem_sel, ir_load, alu_src, mem_to_reg, reg_write, pc_inc,
                 busy, illegal_instr, bus_err, instr_count};

  typedef struct {
    logic        run;
    logic        ack;
    logic [6:0]  op;
    logic [11:0] want;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_base = 0;

  // Reference state: sticky flags and retire count as seen by the next cycle
  logic       m_ill, m_bus;
  logic [1:0] m_cnt;
  int         fill_mode;   // run level in don't-care cycles: 0, 1, or 2 = random

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  function automatic logic fill_run();
    if (fill_mode == 2) return rnd1();
    return (fill_mode == 1);
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%b required=%b (req sel irl asrc m2r rw pci busy ill berr cnt)",
               name, act, want);
    end
  endtask

  task automatic push(input logic r, input logic a, input logic [6:0] op,
                      input logic mreq, input logic msel, input logic irl,
                      input logic asrc, input logic m2r, input logic rw,
                      input logic pci, input logic bsy);
    vec_t v;
    v.run  = r;
    v.ack  = a;
    v.op   = op;
    v.want = {mreq, msel, irl, asrc, m2r, rw, pci, bsy, m_ill, m_bus, m_cnt};
    vq.push_back(v);
  endtask

  // gap IDLE cycles; only the last one raises run
  task automatic add_idle(input int gap);
    for (int j = 0; j < gap; j++)
      push(j == gap - 1, rnd1(), rnd7(), 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One instruction: fd no-ack fetch cycles, md no-ack load cycles,
  // run_end is run at the deciding cycle, gap IDLE cycles if run_end=0
  task automatic add_instr(input logic [6:0] op, input int fd, input int md,
                           input logic run_end, input int gap);
    logic is_r, is_l;
    is_r = (op == OP_R);
    is_l = (op == OP_L);
    for (int j = 0; j < fd; j++) push(fill_run(), 0, rnd7(), 1, 0, 0, 0, 0, 0, 0, 1);
    push(fill_run(), 1, rnd7(), 1, 0, 1, 0, 0, 0, 0, 1);
    if (!is_r && !is_l) begin
      push(run_end, rnd1(), op, 0, 0, 0, 0, 0, 0, 1, 1);
      m_ill = 1'b1;
    end else begin
      push(fill_run(), rnd1(), op, 0, 0, 0, 0, 0, 0, 0, 1);
      push(fill_run(), rnd1(), rnd7(), 0, 0, 0, is_l, 0, 0, 0, 1);
      if (is_l) begin
        for (int j = 0; j < md; j++) push(fill_run(), 0, rnd7(), 1, 1, 0, 1, 0, 0, 0, 1);
        push(fill_run(), 1, rnd7(), 1, 1, 0, 1, 0, 0, 0, 1);
      end
      push(run_end, rnd1(), rnd7(), 0, 0, 0, 0, is_l, 1, 1, 1);
      m_cnt = m_cnt + 2'd1;
    end
    if (!run_end) add_idle(gap);
  endtask

  // Fetch that never acks: 16 wait cycles, then parked in HALT
  task automatic add_timeout();
    for (int j = 0; j < 16; j++) push(fill_run(), 0, rnd7(), 1, 0, 0, 0, 0, 0, 0, 1);
    m_bus = 1'b1;
    for (int j = 0; j < 4; j++) push(rnd1(), rnd1(), rnd7(), 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Drive each record for one cycle and compare mid-cycle; entered at posedge+1
  task automatic apply_all();
    foreach (vq[i]) begin
      run       = vq[i].run;
      mem_ack   = vq[i].ack;
      ir_opcode = vq[i].op;
      @(negedge clk);
      check($sformatf("cyc%0d", vec_base + i), outs, vq[i].want);
      @(posedge clk);
      #1;
    end
    vec_base += vq.size();
    vq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    rst_n = 1'b0; run = 1'b1; mem_ack = 1'b1; ir_opcode = OP_R;
    m_ill = 1'b0; m_bus = 1'b0; m_cnt = 2'd0; fill_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs, 12'h000);
    rst_n = 1'b1;

    // Directed scenarios
    add_idle(1);
    add_instr(OP_R, 0, 0, 1'b1, 0);        // R-type, immediate ack, back-to-back
    add_instr(OP_L, 0, 3, 1'b1, 0);        // load, ack delayed 3 in MEM
    add_instr(7'b1111111, 0, 0, 1'b1, 0);  // illegal opcode
    fill_mode = 0;
    add_instr(OP_L, 1, 1, 1'b0, 2);        // run low from fetch through WB
    fill_mode = 1;
    for (int k = 0; k < 4; k++) add_instr(OP_R, 0, 0, 1'b1, 0);  // count wraps
    apply_all();

    // Randomized instruction stream
    fill_mode = 2;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = OP_R;
        2, 3:    op = OP_L;
        default: begin
          op = rnd7();
          if (op == OP_R || op == OP_L) op = 7'h7F;
        end
      endcase
      add_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), rnd1(),
                $urandom_range(1, 3));
    end
    fill_mode = 1;
    add_instr(OP_R, 15, 0, 1'b1, 0);       // ack on the 16th fetch cycle wins
    add_timeout();
    apply_all();

    // Reset out of HALT, then reset in the middle of a load's MEM wait
    rst_n = 1'b0;
    #1;
    check("async_rst_halt", outs, 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ill = 1'b0; m_bus = 1'b0; m_cnt = 2'd0;
    add_idle(1);
    add_instr(OP_R, 0, 0, 1'b1, 0);
    push(1, 1, rnd7(), 1, 0, 1, 0, 0, 0, 0, 1);
    push(1, 0, OP_L,   0, 0, 0, 0, 0, 0, 0, 1);
    push(1, 0, rnd7(), 0, 0, 0, 1, 0, 0, 0, 1);
    push(1, 0, rnd7(), 1, 1, 0, 1, 0, 0, 0, 1);
    push(1, 0, rnd7(), 1, 1, 0, 1, 0, 0, 0, 1);
    apply_all();
    run = 1'b1; mem_ack = 1'b0;
    #1;
    check("pre_rst_mem", outs, 12'b1101_0001_0001);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem", outs, 12'h000);
    run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 2'd0;
    push(0, rnd1(), rnd7(), 0, 0, 0, 0, 0, 0, 0, 0);
    add_idle(1);
    add_instr(OP_R, 0, 0, 1'b0, 1);
    apply_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
